icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache serving the fetch stage's program counter. Each cycle it looks up `curr_addr` and, on a hit, returns the instruction word combinationally on `iinstr` with `imem_stall` low, so fetch's instruction latch captures it at the next edge. On a miss it raises `imem_stall`, freezing the PC, and refills the whole line from backing memory one word per handshake beat. Once the fill completes, the lookup is retried.

## Interface
- `LINES`, 16: number of cache lines. Power of two, at least 2.
- `WORDS`, 4: 32-bit words per line. Power of two, at least 2.
- `NOP`, 32'h00000013: word driven on `iinstr` whenever `imem_stall`=1 (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, **synchronous, active-low**: sampled on the `clk` rising edge, resets when 0.
- `curr_addr`  in  32  byte address of the fetch PC. Bits [1:0] are ignored.
- `iinstr`  out  32  instruction word for `curr_addr` (combinational on a hit, `NOP` otherwise).
- `imem_stall`  out  1  1 = `iinstr` is not valid this cycle; fetch must hold its PC.
- `inval`  in  1  single-cycle pulse that invalidates every line (used for fence.i).
- `mem_req`  out  1  backing-memory word read request.
- `mem_addr`  out  32  word-aligned byte address of the request; bits [1:0] are always 0.
- `mem_rdata`  in  32  read data, valid when `mem_rvalid`=1.
- `mem_rvalid`  in  1  memory has completed the current request this cycle.

## Operation
- Address split, with OB = log2(WORDS) and IB = log2(LINES):
  - word offset = `curr_addr[2+OB-1:2]`
  - index = `curr_addr[2+OB+IB-1:2+OB]`
  - tag = the remaining upper bits
- Storage:
  - data array of LINES×WORDS×32 bits
  - tag array of LINES entries
  - one valid bit per line
- Hit = state is IDLE and `valid[index]` is set and `tag[index]` equals the tag of `curr_addr` and `inval`=0.
  - On a hit: `iinstr` = data[index][offset] and `imem_stall`=0.
  - Otherwise: `iinstr` = `NOP` and `imem_stall`=1.
- FSM states:
  - IDLE
    - Miss with `inval`=0: capture the miss line address (tag and index) into `fill_addr`, clear the beat counter `k`, go to FILL.
    - `inval`=1: clear all valid bits and stay in IDLE.
  - FILL
    - Drive `mem_req`=1 and `mem_addr`={`fill_addr`, `k`, 2'b00}. Hold both stable until `mem_rvalid`=1.
    - On an edge where `mem_rvalid`=1: write `mem_rdata` to data[index][k], then increment `k`.
    - On the beat where `k`=WORDS-1: write `tag[index]`, set `valid[index]`, go to IDLE.
    - Words fill in order 0..WORDS-1, regardless of which offset missed.
- `mem_rvalid` may be asserted in the same cycle `mem_req` rises (zero-wait memory). `mem_rvalid` is ignored while `mem_req`=0.
- Only one request is outstanding at a time.
- Misses always use the captured `fill_addr`. Changes on `curr_addr` during FILL are ignored; fetch holds it stable anyway.
- `inval` during FILL:
  - It sets a pending flag and does not abort the fill.
  - At fill completion, all valid bits are cleared, including the line just filled, and the FSM returns to IDLE.
  - The retry then misses again.
- Reset (`rst`=0): all valid bits cleared, state IDLE, `k`=0, pending flag cleared. Data and tag arrays are not reset.
  - Reset in the middle of a fill abandons the request; `mem_req` is 0 from the next cycle.

## Timing
Values after reset:
- `imem_stall`=1 (no line is valid yet)
- `iinstr`=`NOP`
- `mem_req`=0
- `mem_addr`=0

Latency:
- Hit: zero cycles, combinational from `curr_addr`.
- Miss, zero-wait memory: 1 IDLE cycle, then WORDS FILL cycles, then a hit on the retry cycle. That is 5 stall cycles at default parameters.
- Each additional memory wait cycle per beat adds one stall cycle.

Simultaneous events:
- `inval` together with a would-be hit: stall that cycle, and the lines are invalid from the next cycle.
- `inval` together with the last fill beat: the pending rule applies, and the line ends invalid.

Other rules:
- `mem_addr` wraps naturally: a line at the top of the 32-bit address space fills words up to 0xFFFFFFFC.
- Tag comparison uses the full tag width, with no partial matching.

## Test plan
- Reset, then `curr_addr`=0x100 with zero-wait memory returning `mem_rdata`=addr^0xA5A5A5A5:
  - `imem_stall`=1 for 5 cycles
  - `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C
  - then `iinstr`=0xA5A5A4A5 with `imem_stall`=0
- After that fill, `curr_addr`=0x108: immediate hit, `iinstr`=0xA5A5A4AD, and `mem_req` stays 0.
- Conflict: fill 0x100, then `curr_addr`=0x200 (same index, different tag):
  - miss, refill of 0x200–0x20C
  - a return to 0x100 misses again
- Memory with 3 wait cycles per beat:
  - `mem_req`/`mem_addr` held stable across the waits
  - stall lasts 1+4×4=17 cycles
- `inval` pulse:
  - in IDLE after fills, the next access to 0x100 misses
  - during FILL of 0x300, the fill completes, then 0x300 misses and refills
- `rst`=0 in the middle of a FILL:
  - next cycle `mem_req`=0 and `imem_stall`=1
  - the partially filled line is not valid, and re-access refetches all 4 words

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache for the fetch stage.
//
// A lookup of curr_addr happens every cycle. A hit returns the word
// combinationally with imem_stall low. A miss raises imem_stall, captures
// the line address and refills the whole line from backing memory, one
// word per request/response beat. Words are always filled in order
// 0..WORDS-1. Once the line is written, the lookup is retried.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-low reset
//   curr_addr   in   [31:0] fetch PC byte address, bits [1:0] ignored
//   iinstr      out  [31:0] instruction word on a hit, NOP otherwise
//   imem_stall  out  1 = iinstr not valid, fetch holds its PC
//   inval       in   one-cycle pulse that invalidates every line
//   mem_req     out  backing-memory word read request
//   mem_addr    out  [31:0] word-aligned request address (0 when idle)
//   mem_rdata   in   [31:0] read data, valid with mem_rvalid
//   mem_rvalid  in   request completes this cycle
//
// Memory handshake: while mem_req=1, mem_addr is held stable. A beat
// completes on every rising edge where mem_req=1 and mem_rvalid=1.
// mem_rvalid may already be high in the first cycle of mem_req (zero-wait
// memory). mem_rvalid is ignored while mem_req=0. Only one request is
// outstanding at a time.

module icache #(
  parameter int          LINES = 16,
  parameter int          WORDS = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] curr_addr,
  output logic [31:0] iinstr,
  output logic        imem_stall,
  input  logic        inval,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 32 - 2 - OB - IB;
  // Line address = tag + index
  localparam int LB = TB + IB;
  localparam logic [OB-1:0] K_LAST = OB'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // FSM state, pending-invalidate flag and fill bookkeeping
  state_t          state_q, state_d;
  logic [OB-1:0]   k_q, k_d;
  logic [LB-1:0]   fill_addr_q, fill_addr_d;
  logic            pend_q, pend_d;
  logic [LINES-1:0] valid_q;

  // Storage. These arrays are not reset; only the valid bits are.
  logic [31:0]   data_mem [LINES][WORDS];
  logic [TB-1:0] tag_mem  [LINES];

  // Lookup address split
  logic [OB-1:0] word_off;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic          hit;
  logic          addr_unused;

  assign word_off    = curr_addr[2+OB-1:2];
  assign idx         = curr_addr[2+OB+IB-1:2+OB];
  assign tag         = curr_addr[31:2+OB+IB];
  assign addr_unused = ^curr_addr[1:0];

  // Line being filled
  logic [IB-1:0] fill_idx;
  logic [TB-1:0] fill_tag;
  logic          beat;
  logic          last_beat;

  assign fill_idx  = fill_addr_q[IB-1:0];
  assign fill_tag  = fill_addr_q[LB-1:IB];
  assign beat      = (state_q == FILL) && mem_rvalid;
  assign last_beat = beat && (k_q == K_LAST);

  // An inval in the same cycle suppresses the hit, so fetch never
  // consumes a word from a line that is being invalidated.
  assign hit = (state_q == IDLE) && valid_q[idx] && (tag_mem[idx] == tag) && !inval;

  assign iinstr     = hit ? data_mem[idx][word_off] : NOP;
  assign imem_stall = !hit;

  // Valid-bit control
  logic valid_clr;
  logic valid_set;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    fill_addr_d = fill_addr_q;
    pend_d      = pend_q;
    valid_clr   = 1'b0;
    valid_set   = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = 32'h0;
    case (state_q)
      IDLE: begin
        if (inval) begin
          valid_clr = 1'b1;
        end else if (!hit) begin
          fill_addr_d = curr_addr[31:2+OB];
          k_d         = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {fill_addr_q, k_q, 2'b00};
        // An inval during a fill is remembered, not acted on, so the
        // outstanding request is always allowed to complete.
        if (inval) begin
          pend_d = 1'b1;
        end
        if (mem_rvalid) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            valid_set = 1'b1;
            // Pending or coincident inval wipes everything, including
            // the line just written, so the retry misses.
            if (pend_q || inval) begin
              valid_clr = 1'b1;
            end
            pend_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      fill_addr_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      fill_addr_q <= fill_addr_d;
      pend_q      <= pend_d;
    end
  end

  // Clear has priority over set so an invalidate always wins at fill end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q <= '0;
    end else if (valid_set) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && beat) begin
      data_mem[fill_idx][k_q] <= mem_rdata;
    end
    if (rst && last_beat) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule
